data_mem_responder: RTL and testbench

//  Data-memory target that answers the active-low strobes n_mem_cs, n_mem_oe and n_mem_rw

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - strobe-driven data memory target with wait states, ack pulse and stall
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_mem_cs,
  input  logic              n_mem_oe,
  input  logic              n_mem_rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        SKIP_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                conflict_q, conflict_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic                req_read;
  logic                req_write;
  logic                req_conflict;
  logic                req_valid;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   rd_word;

  // Strobe decode; a conflict (oe and write both asserted) is served as a read
  always_comb begin
    req_read     = !n_mem_cs && !n_mem_oe;
    req_write    = !n_mem_cs &&  n_mem_oe && n_mem_rw;
    req_conflict = !n_mem_cs && !n_mem_oe && n_mem_rw;
    req_valid    = req_read || req_write;
  end

  // Range check and array read use the latched address only
  always_comb begin
    in_range = ({1'b0, addr_q} < DEPTH_L);
    idx      = addr_q[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : '0;
  end

  // Next-state and registered-output computation for the access FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    conflict_d = conflict_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = addr;
          wdata_d    = wdata;
          write_d    = req_write;
          conflict_d = req_conflict;
          cnt_d      = WAIT_LOAD;
          state_d    = SKIP_WAIT ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (!write_q) begin
          rdata_d = rd_word;
        end
        if (!in_range || conflict_q) begin
          err_d = 1'b1;
        end
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Array write on the edge leaving ACCESS; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && write_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

  // Stall freezes the core while a request is sampled or in service
  always_comb begin
    stall = (state_q == S_WAIT) || (state_q == S_ACCESS) ||
            ((state_q == S_IDLE) && req_valid);
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic       clk;
  logic       a_rst, a_cs, a_oe, a_rw;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       a_ack, a_stall, a_err;
  logic       b_rst, b_cs, b_oe, b_rw;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic       b_ack, b_stall, b_err;

  int tests_run;
  int tests_failed;

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(a_rst), .n_mem_cs(a_cs), .n_mem_oe(a_oe), .n_mem_rw(a_rw),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .stall(a_stall), .err(a_err)
  );

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(b_rst), .n_mem_cs(b_cs), .n_mem_oe(b_oe), .n_mem_rw(b_rw),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack), .stall(b_stall), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = read, 1 = write, 2 = conflict. Strobes released after the sampling edge.
  task automatic run_a(input int kind, input logic [7:0] ad, input logic [7:0] wd,
                       output int ack_edge, output int ack_cnt, output int stall_cnt,
                       output logic [7:0] rd_at_ack);
    ack_edge  = -1;
    ack_cnt   = 0;
    stall_cnt = 0;
    rd_at_ack = 8'h00;
    @(posedge clk); #1;
    a_addr  = ad;
    a_wdata = wd;
    a_cs    = 1'b0;
    a_oe    = (kind == 1) ? 1'b1 : 1'b0;
    a_rw    = (kind == 0) ? 1'b0 : 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == 1) begin
          a_cs = 1'b1; a_oe = 1'b1; a_rw = 1'b1;
        end
      end
      @(negedge clk);
      if (a_stall) stall_cnt++;
      if (a_ack) begin
        ack_cnt++;
        if (ack_edge < 0) begin
          ack_edge  = n;
          rd_at_ack = a_rdata;
        end
      end
    end
  endtask

  task automatic b_write(input logic [7:0] ad, input logic [7:0] wd);
    @(posedge clk); #1;
    b_addr = ad; b_wdata = wd; b_cs = 1'b0; b_oe = 1'b1; b_rw = 1'b1;
    @(posedge clk); #1;
    b_cs = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    a_cs = 1'b1; a_oe = 1'b1; a_rw = 1'b1; a_addr = 8'h00; a_wdata = 8'h00;
    b_cs = 1'b1; b_oe = 1'b1; b_rw = 1'b1; b_addr = 8'h00; b_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (a_ack !== 1'b0 || a_stall !== 1'b0 || a_err !== 1'b0 || a_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: ack=%b stall=%b err=%b rdata=%h required 0 0 0 00",
               a_ack, a_stall, a_err, a_rdata);
    end
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_stall: a=%b b=%b required 0 0", a_stall, b_stall);
    end
  endtask

  task automatic test_write;
    int e, c, s;
    logic [7:0] r;
    run_a(1, 8'h10, 8'hA5, e, c, s, r);
    tests_run++;
    if (e !== 3) begin tests_failed++; $display("FAIL t1_ack_edge: got %0d required 3", e); end
    tests_run++;
    if (c !== 1) begin tests_failed++; $display("FAIL t1_ack_count: got %0d required 1", c); end
    tests_run++;
    if (s !== 3) begin tests_failed++; $display("FAIL t1_stall_cycles: got %0d required 3", s); end
    tests_run++;
    if (a_err !== 1'b0 || a_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL t1_err_rdata: err=%b rdata=%h required 0 00", a_err, a_rdata);
    end
  endtask

  task automatic test_read;
    int e, c, s;
    logic [7:0] r;
    run_a(0, 8'h10, 8'h00, e, c, s, r);
    tests_run++;
    if (e !== 3) begin tests_failed++; $display("FAIL t2_ack_edge: got %0d required 3", e); end
    tests_run++;
    if (r !== 8'hA5) begin tests_failed++; $display("FAIL t2_rdata_at_ack: got %h required a5", r); end
    tests_run++;
    if (a_rdata !== 8'hA5 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL t2_rdata_held: rdata=%h err=%b required a5 0", a_rdata, a_err);
    end
  endtask

  task automatic test_conflict;
    int e, c, s;
    logic [7:0] r;
    run_a(1, 8'h12, 8'h77, e, c, s, r);
    run_a(0, 8'h12, 8'h00, e, c, s, r);
    tests_run++;
    if (r !== 8'h77 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_pre_read: rdata=%h err=%b required 77 0", r, a_err);
    end
    run_a(2, 8'h10, 8'h00, e, c, s, r);
    tests_run++;
    if (e !== 3 || r !== 8'hA5) begin
      tests_failed++;
      $display("FAIL t5_conflict_read: edge=%0d rdata=%h required 3 a5", e, r);
    end
    tests_run++;
    if (a_err !== 1'b1) begin tests_failed++; $display("FAIL t5_err: got %b required 1", a_err); end
  endtask

  task automatic test_out_of_range;
    int e, c, s;
    logic [7:0] r;
    @(posedge clk); #1; a_rst = 1'b1;
    @(posedge clk); #1; a_rst = 1'b0;
    tests_run++;
    if (a_err !== 1'b0) begin tests_failed++; $display("FAIL t4_err_cleared: got %b required 0", a_err); end
    run_a(1, 8'h00, 8'h12, e, c, s, r);
    run_a(1, 8'h80, 8'hFF, e, c, s, r);
    tests_run++;
    if (c !== 1 || a_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_oor_write: acks=%0d err=%b required 1 1", c, a_err);
    end
    run_a(0, 8'h00, 8'h00, e, c, s, r);
    tests_run++;
    if (r !== 8'h12) begin tests_failed++; $display("FAIL t4_no_alias: got %h required 12", r); end
    run_a(0, 8'h80, 8'h00, e, c, s, r);
    tests_run++;
    if (e !== 3 || r !== 8'h00 || a_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL t4_oor_read: edge=%0d rdata=%h/%h required 3 00", e, r, a_rdata);
    end
    tests_run++;
    if (a_err !== 1'b1) begin tests_failed++; $display("FAIL t4_err_sticky: got %b required 1", a_err); end
  endtask

  task automatic test_reset_mid_op;
    int e, c, s;
    int acks;
    logic [7:0] r;
    run_a(1, 8'h20, 8'h11, e, c, s, r);
    run_a(0, 8'h20, 8'h00, e, c, s, r);
    tests_run++;
    if (r !== 8'h11) begin tests_failed++; $display("FAIL t6_pre_read: got %h required 11", r); end
    @(posedge clk); #1;
    a_addr = 8'h20; a_wdata = 8'h3C; a_cs = 1'b0; a_oe = 1'b1; a_rw = 1'b1;
    @(posedge clk); #1;
    a_cs = 1'b1;
    a_rst = 1'b1;
    #1;
    tests_run++;
    if (a_ack !== 1'b0 || a_stall !== 1'b0 || a_err !== 1'b0 || a_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL t6_reset_outputs: ack=%b stall=%b err=%b rdata=%h required 0 0 0 00",
               a_ack, a_stall, a_err, a_rdata);
    end
    @(posedge clk); #1;
    a_rst = 1'b0;
    acks = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    tests_run++;
    if (acks !== 0) begin tests_failed++; $display("FAIL t6_no_ack: got %0d required 0", acks); end
    run_a(0, 8'h20, 8'h00, e, c, s, r);
    tests_run++;
    if (r !== 8'h11) begin tests_failed++; $display("FAIL t6_write_aborted: got %h required 11", r); end
  endtask

  task automatic test_back_to_back;
    int ack_n[2];
    logic [7:0] ack_r[2];
    int acks;
    int stalls;
    b_write(8'h10, 8'hC3);
    b_write(8'h11, 8'h96);
    acks = 0;
    stalls = 0;
    ack_n[0] = -1; ack_n[1] = -1;
    ack_r[0] = 8'h00; ack_r[1] = 8'h00;
    @(posedge clk); #1;
    b_addr = 8'h10; b_cs = 1'b0; b_oe = 1'b0; b_rw = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == 1) b_addr = 8'h11;
        if (n == 5) b_cs = 1'b1;
      end
      @(negedge clk);
      if (b_stall) stalls++;
      if (b_ack) begin
        if (acks < 2) begin
          ack_n[acks] = n;
          ack_r[acks] = b_rdata;
        end
        acks++;
      end
    end
    tests_run++;
    if (acks !== 2) begin tests_failed++; $display("FAIL t3_ack_count: got %0d required 2", acks); end
    tests_run++;
    if (ack_n[0] !== 2 || ack_n[1] !== 5) begin
      tests_failed++;
      $display("FAIL t3_ack_edges: got %0d,%0d required 2,5", ack_n[0], ack_n[1]);
    end
    tests_run++;
    if (ack_r[0] !== 8'hC3 || ack_r[1] !== 8'h96) begin
      tests_failed++;
      $display("FAIL t3_rdata: got %h,%h required c3,96", ack_r[0], ack_r[1]);
    end
    tests_run++;
    if (stalls !== 4 || b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_stall_err: stalls=%0d err=%b required 4 0", stalls, b_err);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_write;
    test_read;
    test_conflict;
    test_out_of_range;
    test_reset_mid_op;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
